// File: rtl/seg7_pkg.sv
// Shared constants for seven-segment capture and decode blocks.
// Segment bit order is gfedcba, 1 = segment lit.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        LOCKED = 2'd2
    } state_t;

endpackage

// File: rtl/seg7_lut.sv
// Combinational seven-segment decoder. is_valid flags a recognised digit
// pattern only; blank is reported separately and any range limit on the
// digit is left to the user of this block.
module seg7_lut
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] digit,
    output logic       is_blank,
    output logic       is_valid
);

    // Pattern to digit lookup; unknown patterns decode as invalid digit 0.
    always_comb begin
        digit    = 4'd0;
        is_valid = 1'b1;
        is_blank = (seg == SEG_BLANK);
        case (seg)
            SEG_0:   digit = 4'd0;
            SEG_1:   digit = 4'd1;
            SEG_2:   digit = 4'd2;
            SEG_3:   digit = 4'd3;
            SEG_4:   digit = 4'd4;
            SEG_5:   digit = 4'd5;
            SEG_6:   digit = 4'd6;
            SEG_7:   digit = 4'd7;
            SEG_8:   digit = 4'd8;
            SEG_9:   digit = 4'd9;
            default: is_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_capture.sv
// Debounces a seven-segment display bus and turns digit changes into a
// valid/ready event stream with rollover, blank, error and overrun flags.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | nothing accepted since reset (or reset release not yet synced)
// SETTLE | counting consecutive identical samples of a candidate pattern
// LOCKED | candidate accepted; waiting for the bus to change
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned MAX_DIGIT     = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] seg,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [3:0] digit,
    output logic       wrap,
    output logic       blank,
    output logic       err,
    output logic       overrun
);

    localparam logic [3:0] STABLE_C = 4'(STABLE_CYCLES);
    localparam logic [3:0] MAX_C    = 4'(MAX_DIGIT);

    logic [1:0] rst_sync;
    logic       run;
    logic [6:0] samp;
    state_t     state_q, state_d;
    logic [6:0] cand_q, cand_d;
    logic [3:0] cnt_q, cnt_d, cnt_inc;
    logic       accept;
    logic [3:0] lut_digit;
    logic       lut_blank, lut_valid;
    logic       dig_ok, is_event, is_wrap;
    logic [3:0] last_q;
    logic       have_q;

    // Reset release is brought onto clk before the FSM may leave IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end

    assign run = rst_sync[1];

    // Single input register; every decision below looks only at samp.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) samp <= 7'd0;
        else        samp <= seg;
    end

    seg7_lut u_lut (
        .seg      (samp),
        .digit    (lut_digit),
        .is_blank (lut_blank),
        .is_valid (lut_valid)
    );

    // FSM state, candidate pattern and stability count registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cand_q  <= 7'd0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: cand holds the pattern being counted, or the accepted one
    // while LOCKED, so a single compare serves both stability and re-lock.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        cnt_inc = (cnt_q >= STABLE_C) ? STABLE_C : cnt_q + 4'd1;
        case (state_q)
            IDLE: begin
                if (run) begin
                    cand_d  = samp;
                    cnt_d   = 4'd1;
                    state_d = SETTLE;
                    if (cnt_d >= STABLE_C) begin
                        accept  = 1'b1;
                        state_d = LOCKED;
                    end
                end
            end
            SETTLE: begin
                cand_d = samp;
                cnt_d  = (samp == cand_q) ? cnt_inc : 4'd1;
                if (cnt_d >= STABLE_C) begin
                    accept  = 1'b1;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (samp != cand_q) begin
                    cand_d  = samp;
                    cnt_d   = 4'd1;
                    state_d = SETTLE;
                    if (cnt_d >= STABLE_C) begin
                        accept  = 1'b1;
                        state_d = LOCKED;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // have_q makes the first digit after reset an event even when it is 0.
    assign dig_ok   = lut_valid && (lut_digit <= MAX_C);
    assign is_event = accept && dig_ok && (!have_q || (lut_digit != last_q));
    assign is_wrap  = have_q && (last_q == MAX_C) && (lut_digit == 4'd0);

    // Accepted-pattern bookkeeping and the output event register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q    <= 4'd0;
            have_q    <= 1'b0;
            out_valid <= 1'b0;
            digit     <= 4'd0;
            wrap      <= 1'b0;
            blank     <= 1'b0;
            err       <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            err <= accept && !lut_blank && !dig_ok;
            if (accept && lut_blank) begin
                blank <= 1'b1;
            end else if (accept && dig_ok) begin
                blank  <= 1'b0;
                last_q <= lut_digit;
                have_q <= 1'b1;
            end
            if (is_event) begin
                out_valid <= 1'b1;
                digit     <= lut_digit;
                wrap      <= is_wrap;
                if (out_valid && !out_ready) overrun <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/seg7_capture.md
SEG7_CAPTURE -- requirements
Module: seg7_capture

Interface
REQ-001 Parameter: STABLE_CYCLES, 4, consecutive identical samples required to accept a pattern (range 1..15).
REQ-002 Parameter: MAX_DIGIT, 5, highest legal digit; decoded digits above it are treated as invalid.
REQ-003 Port: clk  input  1  single clock, rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: seg  input  7  segment pattern, bit order gfedcba, 1 = segment lit.
REQ-006 Port: out_ready  input  1  consumer accepts the pending event.
REQ-007 Port: out_valid  output  1  a digit event is pending.
REQ-008 Port: digit  output  4  decoded digit of the pending event, 0..9.
REQ-009 Port: wrap  output  1  pending event is a MAX_DIGIT->0 rollover.
REQ-010 Port: blank  output  1  last accepted pattern was all-off.
REQ-011 Port: err  output  1  one-cycle pulse when an invalid pattern is accepted.
REQ-012 Port: overrun  output  1  sticky; an event was overwritten before being consumed.

Function
REQ-013 seg is registered once; all decisions use the registered sample (1-cycle input latency).
REQ-014 Decode: 0111111=0, 0000110=1, 1011011=2, 1001111=3, 1100110=4, 1101101=5, 1111101=6, 0000111=7, 1111111=8, 1101111=9, 0000000=blank; all other codes invalid; digit > MAX_DIGIT is invalid.
REQ-015 FSM states: IDLE (nothing accepted), SETTLE (counting stability), LOCKED (pattern accepted).
REQ-016 IDLE -> SETTLE on any sample; SETTLE counts while sample equals the previous sample and restarts the count at 1 on any change.
REQ-017 SETTLE -> LOCKED when the count reaches STABLE_CYCLES; acceptance occurs on that cycle.
REQ-018 LOCKED -> SETTLE when the sample differs from the accepted pattern; an identical sample keeps LOCKED with no new event.
REQ-019 Accepting a valid digit that differs from the last accepted digit raises out_valid with digit on the next cycle; re-accepting the same digit (after a glitch) produces no event.
REQ-020 wrap = 1 on an event whose previous accepted digit was MAX_DIGIT and new digit is 0; otherwise 0.
REQ-021 Accepting blank sets blank, produces no event, and preserves the last accepted digit; accepting a digit clears blank.
REQ-022 Accepting an invalid pattern pulses err for exactly one cycle, produces no event, and preserves the last accepted digit.
REQ-023 out_valid, digit and wrap hold stable until the cycle out_valid && out_ready; out_valid then drops unless a new event loads on the same cycle.
REQ-024 New event while out_valid && !out_ready: overwrite digit/wrap, keep out_valid high, set overrun; overrun clears only on reset.
REQ-025 New event on the same cycle as a handshake: the new event loads, out_valid stays high, overrun not set.
REQ-026 Stability counter saturates at STABLE_CYCLES; no arithmetic wrap.

Reset
REQ-027 reset low asynchronously forces IDLE, count 0, sample register 0, last digit 0, out_valid 0, digit 0, wrap 0, blank 0, err 0, overrun 0.
REQ-028 Reset asserted mid-SETTLE or with an event pending discards all state; the first accepted digit after reset is always an event (no wrap).
REQ-029 Release of reset is synchronised to clk before the FSM leaves IDLE.

Structure
REQ-030 Shared package seg7_pkg holds the ten digit pattern constants, the BLANK constant and the state enum (IDLE, SETTLE, LOCKED).
REQ-031 Decode lives in one combinational sub-module seg7_lut (seg in; digit, is_blank, is_valid out), reusable by other display blocks.

Verification
REQ-032 Hold seg=1101101 for 6 cycles after reset -> out_valid rises with digit=5, wrap=0, exactly 5 cycles after first sample (1 register + 4 stable).
REQ-033 Step 5->0111111 with out_ready=1 -> one event digit=0, wrap=1; then hold -> no further events.
REQ-034 From locked 3, glitch 1011011 for 2 cycles then back to 1001111 -> no event, no err.
REQ-035 Apply 1111101 (6) stable with MAX_DIGIT=5 -> err pulses one cycle, no event; apply 0110000 -> err, no event.
REQ-036 out_ready=0, accept 1 then 2 -> digit=2, out_valid=1, overrun=1; assert out_ready -> out_valid drops next cycle, overrun stays 1.
REQ-037 Assert reset while SETTLE count=2 with event pending -> all outputs 0 immediately; after release, stable 4 -> event digit=4, wrap=0.
